aip_port_router: RTL and testbench
==================================

# aip_port_router

Parametrised AIP port router that connects one upstream AIP master interface to N_PORTS downstream AIP slave ports. It forwards config/read/write/start traffic to a software-selected port, and adds sticky per-port interrupt capture, per-port busy tracking, interrupt masking and a single aggregated interrupt request. It sits between the coprocessor-side master port and the IP-core slave ports, replacing fixed per-port wiring.

## Interface
- DATA_WORD, 32, width of AIP data words.
- N_PORTS, 3, number of downstream slave ports; legal range 1..8.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_a  in  1  asynchronous, active-low reset.
- i_config  in  5  upstream AIP config code.
- i_read  in  1  upstream read strobe, one cycle per access.
- i_write  in  1  upstream write strobe, one cycle per access.
- i_start  in  1  upstream start strobe.
- i_data_in  in  DATA_WORD  upstream write data.
- o_data_out  out  DATA_WORD  registered read data.
- o_int_req  out  1  aggregated masked interrupt, registered.
- o_configAIP_IP  out  5*N_PORTS  per-port config; port k occupies bits [5k+4:5k].
- o_dataInAIP_IP  out  DATA_WORD*N_PORTS  per-port write data, broadcast to every port.
- o_readAIP_IP  out  N_PORTS  per-port read strobe.
- o_writeAIP_IP  out  N_PORTS  per-port write strobe.
- o_start_IP  out  N_PORTS  per-port start strobe.
- i_dataOutAIP_IP  in  DATA_WORD*N_PORTS  per-port read data, combinational on that port's config.
- i_int_IP  in  N_PORTS  per-port interrupt level, synchronous to i_clk.

## Operation
- Local register codes (never forwarded):
  - 5'h1F SEL: write bits [2:0] = target port. A write with value >= N_PORTS is ignored and SEL is unchanged.
  - 5'h1E STATUS: read only. [7:0] = pending, [15:8] = busy, [18:16] = SEL, rest zero.
  - 5'h1D MASK: read/write, bits [N_PORTS-1:0]; 1 = interrupt enabled.
  - 5'h1C CLEAR: write-1-to-clear pending bits; reads return 0.
- All other codes (5'h00–5'h1B):
  - i_config is driven to every port's config field.
  - i_read and i_write are gated to the selected port only; the other ports see 0.
  - i_start is forwarded to the selected port regardless of i_config.
- Read path: when i_read is high, o_data_out captures either the local register or the selected port's i_dataOutAIP_IP slice. That value holds until the next i_read.
- Interrupt capture:
  - prev_int register per port; a rising edge is i_int_IP & ~prev_int.
  - A rising edge sets pending[k].
  - A CLEAR write with bit k = 1 clears pending[k].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Busy:
  - A start forwarded to port k sets busy[k].
  - A rising interrupt edge on port k clears busy[k].
  - If both happen in the same cycle, busy[k] stays 1.
- o_int_req = |(pending & MASK), registered.
- Bits at index >= N_PORTS in pending, busy and MASK read as 0.

## Timing
- Reset values: SEL=0, MASK=0, pending=0, busy=0, prev_int=0, o_data_out=0, o_int_req=0.
- During reset, forwarded strobes are forced to 0. Reset mid-access aborts the access; no strobe is emitted after reset deasserts unless newly requested.
- Forwarded config, data, read, write and start are combinational from the upstream inputs, with zero latency.
- o_data_out is valid 1 cycle after i_read.
- SEL, MASK and CLEAR writes take effect on the next edge. A read of STATUS in the cycle after a write reflects the written value.
- Interrupt latency: i_int_IP rises in cycle n. pending is set at edge n+1, and o_int_req rises at edge n+2.
- A level held high produces only one pending set. pending re-arms only after the input goes low.
- Changing SEL while the old port is busy does not change its busy or pending bits.

## Test plan
- Reset behaviour: assert i_rst_a=0 mid-run with traffic -> all outputs 0, SEL=0, MASK=0 immediately (asynchronous); after release, STATUS reads 0.
- Select and forward:
  - Write SEL=2, then write config 5'h03 with data 32'hA5A5_0001 -> only o_writeAIP_IP[2]=1.
  - Read config 5'h03 with port-2 dataout = 32'h1234_5678 -> o_data_out = 32'h1234_5678 one cycle later.
- Invalid select: write SEL=5 with N_PORTS=3 -> STATUS[18:16] is unchanged; the next forwarded write still goes to the previous port.
- Busy/interrupt round trip:
  - SEL=1, MASK=3'b010, start -> busy[1]=1.
  - Pulse i_int_IP[1] -> pending[1]=1 at n+1, o_int_req=1 at n+2, busy[1]=0.
  - CLEAR 3'b010 -> o_int_req=0 two cycles later.
- Masking and collision:
  - Set MASK=0 and raise int on port 0 -> pending[0]=1, o_int_req stays 0.
  - CLEAR bit 1 in the same cycle as a new edge on port 1 -> pending[1] remains 1.
- Held level and start/int collision:
  - Hold i_int_IP[2] high for 10 cycles, CLEAR after cycle 3 -> pending[2] stays 0 until the input falls and rises again.
  - Start port 2 in the same cycle as its edge -> busy[2]=1.

Source files
------------

// File: rtl/aip_port_router_if.sv
// Upstream AIP bus between the coprocessor-side master and the port router.
// The master drives config/strobes/write data; the router returns registered
// read data and the aggregated interrupt request.
interface aip_port_router_if #(
    parameter int DATA_WORD = 32
);
    logic [4:0]           cfg;
    logic                 rd;
    logic                 wr;
    logic                 start;
    logic [DATA_WORD-1:0] data_in;
    logic [DATA_WORD-1:0] data_out;
    logic                 int_req;

    modport master (
        output cfg, rd, wr, start, data_in,
        input  data_out, int_req
    );

    modport slave (
        input  cfg, rd, wr, start, data_in,
        output data_out, int_req
    );
endinterface

// File: rtl/aip_port_router.sv
// AIP port router: one upstream AIP master fanned out to N_PORTS slave ports.
// Codes 0x1C..0x1F are local registers (SEL, STATUS, MASK, CLEAR) and are never
// forwarded; every other code reaches the selected port with zero latency.
// Adds sticky per-port interrupt capture, busy tracking, masking and a single
// registered interrupt request.
module aip_port_router #(
    parameter int DATA_WORD = 32,
    parameter int N_PORTS   = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst_a,
    aip_port_router_if.slave               aip_up,
    output logic [5*N_PORTS-1:0]           o_configAIP_IP,
    output logic [DATA_WORD*N_PORTS-1:0]   o_dataInAIP_IP,
    output logic [N_PORTS-1:0]             o_readAIP_IP,
    output logic [N_PORTS-1:0]             o_writeAIP_IP,
    output logic [N_PORTS-1:0]             o_start_IP,
    input  logic [DATA_WORD*N_PORTS-1:0]   i_dataOutAIP_IP,
    input  logic [N_PORTS-1:0]             i_int_IP
);

    localparam logic [4:0] ADDR_SEL    = 5'h1F;
    localparam logic [4:0] ADDR_STATUS = 5'h1E;
    localparam logic [4:0] ADDR_MASK   = 5'h1D;
    localparam logic [4:0] ADDR_CLEAR  = 5'h1C;

    logic [2:0]           r_sel;
    logic [N_PORTS-1:0]   r_mask;
    logic [N_PORTS-1:0]   r_pending;
    logic [N_PORTS-1:0]   r_busy;
    logic [N_PORTS-1:0]   r_prev_int;
    logic [DATA_WORD-1:0] r_data_out;
    logic                 r_int_req;

    logic                 w_local;
    logic                 w_sel_wr;
    logic                 w_mask_wr;
    logic [N_PORTS-1:0]   w_clr;
    logic [N_PORTS-1:0]   w_rise;
    logic [7:0]           w_pend8;
    logic [7:0]           w_busy8;
    logic [DATA_WORD-1:0] w_status;
    logic [DATA_WORD-1:0] w_mask_rd;
    logic [DATA_WORD-1:0] w_port_rd;
    logic [DATA_WORD-1:0] w_rd_data;

    // Local register decode; SEL writes naming a non-existent port are dropped.
    always_comb begin
        w_local   = (aip_up.cfg >= ADDR_CLEAR);
        w_sel_wr  = aip_up.wr && (aip_up.cfg == ADDR_SEL) &&
                    ({1'b0, aip_up.data_in[2:0]} < 4'(N_PORTS));
        w_mask_wr = aip_up.wr && (aip_up.cfg == ADDR_MASK);
        w_clr     = (aip_up.wr && (aip_up.cfg == ADDR_CLEAR)) ?
                    aip_up.data_in[N_PORTS-1:0] : '0;
        w_rise    = i_int_IP & ~r_prev_int;
    end

    // Zero-latency forwarding; everything is held at 0 while reset is asserted.
    always_comb begin
        o_configAIP_IP = '0;
        o_dataInAIP_IP = '0;
        o_readAIP_IP   = '0;
        o_writeAIP_IP  = '0;
        o_start_IP     = '0;
        if (i_rst_a) begin
            for (int k = 0; k < N_PORTS; k++) begin
                o_configAIP_IP[5*k +: 5]                 = w_local ? 5'h00 : aip_up.cfg;
                o_dataInAIP_IP[DATA_WORD*k +: DATA_WORD] = aip_up.data_in;
                if (r_sel == 3'(k)) begin
                    o_readAIP_IP[k]  = aip_up.rd && !w_local;
                    o_writeAIP_IP[k] = aip_up.wr && !w_local;
                    // start goes to the selected port whatever the config code
                    o_start_IP[k]    = aip_up.start;
                end
            end
        end
    end

    // Read data selection: local registers zero-extended, else the selected port.
    always_comb begin
        w_pend8                    = '0;
        w_pend8[N_PORTS-1:0]       = r_pending;
        w_busy8                    = '0;
        w_busy8[N_PORTS-1:0]       = r_busy;
        w_status                   = '0;
        w_status[18:0]             = {r_sel, w_busy8, w_pend8};
        w_mask_rd                  = '0;
        w_mask_rd[N_PORTS-1:0]     = r_mask;
        w_port_rd                  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (r_sel == 3'(k)) begin
                w_port_rd = i_dataOutAIP_IP[DATA_WORD*k +: DATA_WORD];
            end
        end
        case (aip_up.cfg)
            ADDR_SEL:    w_rd_data = DATA_WORD'(r_sel);
            ADDR_STATUS: w_rd_data = w_status;
            ADDR_MASK:   w_rd_data = w_mask_rd;
            ADDR_CLEAR:  w_rd_data = '0;
            default:     w_rd_data = w_port_rd;
        endcase
    end

    // Configuration registers: port select and interrupt mask.
    always_ff @(posedge i_clk or negedge i_rst_a) begin
        if (!i_rst_a) begin
            r_sel  <= 3'd0;
            r_mask <= '0;
        end else begin
            if (w_sel_wr)  r_sel  <= aip_up.data_in[2:0];
            if (w_mask_wr) r_mask <= aip_up.data_in[N_PORTS-1:0];
        end
    end

    // Interrupt edge capture and busy tracking; a new edge beats a clear,
    // a new start beats the completing edge.
    always_ff @(posedge i_clk or negedge i_rst_a) begin
        if (!i_rst_a) begin
            r_prev_int <= '0;
            r_pending  <= '0;
            r_busy     <= '0;
        end else begin
            r_prev_int <= i_int_IP;
            r_pending  <= w_rise | (r_pending & ~w_clr);
            r_busy     <= o_start_IP | (r_busy & ~w_rise);
        end
    end

    // Registered read data (held between reads) and aggregated interrupt.
    always_ff @(posedge i_clk or negedge i_rst_a) begin
        if (!i_rst_a) begin
            r_data_out <= '0;
            r_int_req  <= 1'b0;
        end else begin
            r_int_req <= |(r_pending & r_mask);
            if (aip_up.rd) r_data_out <= w_rd_data;
        end
    end

    assign aip_up.data_out = r_data_out;
    assign aip_up.int_req  = r_int_req;

endmodule

// File: tb/tb_aip_port_router.sv
// Bench for aip_port_router: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the register/interrupt rules.
module tb_aip_port_router;
    localparam int DW = 32;
    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5*NP-1:0]  cfg_ip;
    logic [DW*NP-1:0] din_ip;
    logic [DW*NP-1:0] dout_ip = '0;
    logic [NP-1:0]    rd_ip, wr_ip, st_ip;
    logic [NP-1:0]    int_ip = '0;

    int n_vec = 0;
    int n_err = 0;

    int          m_sel;
    logic [NP-1:0] m_mask, m_pend, m_busy, m_prev;
    logic [DW-1:0] m_dout;
    logic          m_ireq;

    always #5 clk = ~clk;

    aip_port_router_if #(.DATA_WORD(DW)) u_if();

    aip_port_router #(.DATA_WORD(DW), .N_PORTS(NP)) dut (
        .i_clk           (clk),
        .i_rst_a         (rst_n),
        .aip_up          (u_if),
        .o_configAIP_IP  (cfg_ip),
        .o_dataInAIP_IP  (din_ip),
        .o_readAIP_IP    (rd_ip),
        .o_writeAIP_IP   (wr_ip),
        .o_start_IP      (st_ip),
        .i_dataOutAIP_IP (dout_ip),
        .i_int_IP        (int_ip)
    );

    task automatic drive(input logic [4:0] c, input logic r, input logic w,
                         input logic s, input logic [DW-1:0] d);
        u_if.cfg = c; u_if.rd = r; u_if.wr = w; u_if.start = s; u_if.data_in = d;
    endtask

    task automatic idle();
        drive(5'h00, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic model_reset();
        m_sel = 0; m_mask = '0; m_pend = '0; m_busy = '0; m_prev = '0;
        m_dout = '0; m_ireq = 1'b0;
    endtask

    // One clock: check forwarded outputs, advance the model, check registered outputs.
    task automatic tick();
        logic fwd;
        logic [NP-1:0] e_rd, e_wr, e_st, rise, clr, n_mask, n_pend, n_busy, n_prev;
        logic [5*NP-1:0] e_cfg;
        logic [DW*NP-1:0] e_din;
        logic [DW-1:0] n_dout, stat, mrd;
        logic n_ireq;
        int n_sel;
        #1;
        fwd = (u_if.cfg < 5'h1C);
        e_rd = '0; e_wr = '0; e_st = '0; e_cfg = '0; e_din = '0;
        if (rst_n) begin
            if (u_if.rd && fwd) e_rd[m_sel] = 1'b1;
            if (u_if.wr && fwd) e_wr[m_sel] = 1'b1;
            if (u_if.start)     e_st[m_sel] = 1'b1;
            for (int k = 0; k < NP; k++) begin
                e_cfg[5*k +: 5]   = fwd ? u_if.cfg : 5'h00;
                e_din[DW*k +: DW] = u_if.data_in;
            end
        end
        n_vec++;
        if ({rd_ip, wr_ip, st_ip} !== {e_rd, e_wr, e_st}) begin
            n_err++;
            $display("FAIL strobes: got rd=%b wr=%b st=%b, want rd=%b wr=%b st=%b",
                     rd_ip, wr_ip, st_ip, e_rd, e_wr, e_st);
        end
        n_vec++;
        if ({cfg_ip, din_ip} !== {e_cfg, e_din}) begin
            n_err++;
            $display("FAIL fwd_cfg_data: got cfg=%h data=%h, want cfg=%h data=%h",
                     cfg_ip, din_ip, e_cfg, e_din);
        end
        rise   = int_ip & ~m_prev;
        clr    = (u_if.wr && u_if.cfg == 5'h1C) ? u_if.data_in[NP-1:0] : '0;
        n_pend = rise | (m_pend & ~clr);
        n_busy = e_st | (m_busy & ~rise);
        n_ireq = |(m_pend & m_mask);
        n_prev = int_ip;
        stat = '0; stat[NP-1:0] = m_pend; stat[8 +: NP] = m_busy; stat[18:16] = 3'(m_sel);
        mrd = '0; mrd[NP-1:0] = m_mask;
        n_dout = m_dout;
        if (u_if.rd) begin
            case (u_if.cfg)
                5'h1F:   n_dout = DW'(m_sel);
                5'h1E:   n_dout = stat;
                5'h1D:   n_dout = mrd;
                5'h1C:   n_dout = '0;
                default: n_dout = dout_ip[DW*m_sel +: DW];
            endcase
        end
        n_sel = m_sel;
        if (u_if.wr && u_if.cfg == 5'h1F && int'(u_if.data_in[2:0]) < NP)
            n_sel = int'(u_if.data_in[2:0]);
        n_mask = m_mask;
        if (u_if.wr && u_if.cfg == 5'h1D) n_mask = u_if.data_in[NP-1:0];
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_sel = n_sel; m_mask = n_mask; m_pend = n_pend; m_busy = n_busy;
            m_prev = n_prev; m_dout = n_dout; m_ireq = n_ireq;
        end
        n_vec++;
        if (u_if.data_out !== m_dout) begin
            n_err++;
            $display("FAIL data_out: got %h, want %h", u_if.data_out, m_dout);
        end
        n_vec++;
        if (u_if.int_req !== m_ireq) begin
            n_err++;
            $display("FAIL int_req: got %b, want %b", u_if.int_req, m_ireq);
        end
    endtask

    task automatic read_status();
        drive(5'h1E, 1'b1, 1'b0, 1'b0, '0);
        tick();
        idle();
    endtask

    task automatic test_reset();
        model_reset();
        drive(5'h03, 1'b1, 1'b1, 1'b1, '1);
        tick();
        tick();
        n_vec++;
        if ({rd_ip, wr_ip, st_ip, u_if.int_req} !== 10'b0 || u_if.data_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got strobes=%b data=%h irq=%b, want all 0",
                     {rd_ip, wr_ip, st_ip}, u_if.data_out, u_if.int_req);
        end
        rst_n = 1'b1;
        idle();
        read_status();
        n_vec++;
        if (u_if.data_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_status: got %h, want 00000000", u_if.data_out);
        end
    endtask

    task automatic test_select_forward();
        drive(5'h1F, 1'b0, 1'b1, 1'b0, 32'd2);
        tick();
        drive(5'h03, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
        #1;
        n_vec++;
        if (wr_ip !== 3'b100 || cfg_ip[14:10] !== 5'h03) begin
            n_err++;
            $display("FAIL sel_write: got wr=%b cfg2=%h, want wr=100 cfg2=03", wr_ip, cfg_ip[14:10]);
        end
        tick();
        dout_ip[64 +: 32] = 32'h1234_5678;
        drive(5'h03, 1'b1, 1'b0, 1'b0, '0);
        tick();
        idle();
        n_vec++;
        if (u_if.data_out !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL port_read: got %h, want 12345678", u_if.data_out);
        end
    endtask

    task automatic test_invalid_select();
        drive(5'h1F, 1'b0, 1'b1, 1'b0, 32'd5);
        tick();
        read_status();
        n_vec++;
        if (u_if.data_out[18:16] !== 3'd2) begin
            n_err++;
            $display("FAIL invalid_sel: got sel=%0d, want 2", u_if.data_out[18:16]);
        end
        drive(5'h05, 1'b0, 1'b1, 1'b0, 32'h0BAD_0005);
        #1;
        n_vec++;
        if (wr_ip !== 3'b100) begin
            n_err++;
            $display("FAIL invalid_sel_fwd: got wr=%b, want 100", wr_ip);
        end
        tick();
        idle();
    endtask

    task automatic test_busy_int();
        drive(5'h1F, 1'b0, 1'b1, 1'b0, 32'd1);
        tick();
        drive(5'h1D, 1'b0, 1'b1, 1'b0, 32'd2);
        tick();
        drive(5'h00, 1'b0, 1'b0, 1'b1, '0);
        #1;
        n_vec++;
        if (st_ip !== 3'b010) begin
            n_err++;
            $display("FAIL start_fwd: got %b, want 010", st_ip);
        end
        tick();
        idle();
        read_status();
        n_vec++;
        if (u_if.data_out !== 32'h0001_0200) begin
            n_err++;
            $display("FAIL busy_set: got status %h, want 00010200", u_if.data_out);
        end
        int_ip[1] = 1'b1;
        tick();
        n_vec++;
        if (u_if.int_req !== 1'b0) begin
            n_err++;
            $display("FAIL irq_n1: got %b, want 0", u_if.int_req);
        end
        int_ip[1] = 1'b0;
        tick();
        n_vec++;
        if (u_if.int_req !== 1'b1) begin
            n_err++;
            $display("FAIL irq_n2: got %b, want 1", u_if.int_req);
        end
        read_status();
        n_vec++;
        if (u_if.data_out !== 32'h0001_0002) begin
            n_err++;
            $display("FAIL pend_busy: got status %h, want 00010002", u_if.data_out);
        end
        drive(5'h1C, 1'b0, 1'b1, 1'b0, 32'd2);
        tick();
        idle();
        n_vec++;
        if (u_if.int_req !== 1'b1) begin
            n_err++;
            $display("FAIL irq_clear_c0: got %b, want 1", u_if.int_req);
        end
        tick();
        n_vec++;
        if (u_if.int_req !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear_c1: got %b, want 0", u_if.int_req);
        end
    endtask

    task automatic test_mask_collision();
        drive(5'h1D, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        idle();
        int_ip[0] = 1'b1;
        tick();
        int_ip[0] = 1'b0;
        tick();
        tick();
        n_vec++;
        if (u_if.int_req !== 1'b0) begin
            n_err++;
            $display("FAIL masked_irq: got %b, want 0", u_if.int_req);
        end
        read_status();
        n_vec++;
        if (u_if.data_out[0] !== 1'b1) begin
            n_err++;
            $display("FAIL masked_pend: got %b, want 1", u_if.data_out[0]);
        end
        drive(5'h1C, 1'b0, 1'b1, 1'b0, 32'd2);
        int_ip[1] = 1'b1;
        tick();
        int_ip[1] = 1'b0;
        idle();
        read_status();
        n_vec++;
        if (u_if.data_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL set_beats_clear: got %b, want 1", u_if.data_out[1]);
        end
    endtask

    task automatic test_held_level();
        drive(5'h1F, 1'b0, 1'b1, 1'b0, 32'd2);
        tick();
        drive(5'h1C, 1'b0, 1'b1, 1'b0, 32'd7);
        tick();
        idle();
        int_ip[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive(5'h1C, 1'b0, 1'b1, 1'b0, 32'd4);
            else        idle();
            tick();
        end
        read_status();
        n_vec++;
        if (u_if.data_out[2] !== 1'b0) begin
            n_err++;
            $display("FAIL held_level: got pend2=%b, want 0", u_if.data_out[2]);
        end
        int_ip[2] = 1'b0;
        tick();
        int_ip[2] = 1'b1;
        drive(5'h00, 1'b0, 1'b0, 1'b1, '0);
        tick();
        idle();
        read_status();
        n_vec++;
        if ({u_if.data_out[10], u_if.data_out[2]} !== 2'b11) begin
            n_err++;
            $display("FAIL start_int_collision: got busy2=%b pend2=%b, want 1 1",
                     u_if.data_out[10], u_if.data_out[2]);
        end
        int_ip[2] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] c;
        int op;
        for (int i = 0; i < 400; i++) begin
            int_ip  = int_ip ^ NP'($urandom_range(0, 7) & $urandom_range(0, 7));
            dout_ip = {$urandom, $urandom, $urandom};
            c = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 27));
            op = $urandom_range(0, 2);
            if (op == 1 && c == 5'h1F) c = 5'h1E;
            drive(c, op == 1, op == 2, $urandom_range(0, 5) == 0,
                  (c == 5'h1F) ? DW'($urandom_range(0, 7)) : DW'($urandom));
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        drive(5'h1D, 1'b0, 1'b1, 1'b0, 32'd7);
        tick();
        drive(5'h03, 1'b1, 1'b1, 1'b1, '1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_ip, wr_ip, st_ip, u_if.int_req} !== 10'b0 || u_if.data_out !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got strobes=%b data=%h irq=%b, want all 0",
                     {rd_ip, wr_ip, st_ip}, u_if.data_out, u_if.int_req);
        end
        model_reset();
        int_ip = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        read_status();
        n_vec++;
        if (u_if.data_out !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_status: got %h, want 00000000", u_if.data_out);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_select_forward();
        test_invalid_select();
        test_busy_int();
        test_mask_collision();
        test_held_level();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
